// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared RISC-V opcodes, ALUOp codes and control-word layout
package rv_ctrl_pkg;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch_eq;
    logic       branch_gt;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_word_t;
  localparam int CW_W          = $bits(ctrl_word_t);
  localparam int CW_REG_WRITE  = 0;
  localparam int CW_MEM_TO_REG = 1;
  localparam int CW_MEM_WRITE  = 2;
  localparam int CW_MEM_READ   = 3;
  localparam int CW_BRANCH_GT  = 4;
  localparam int CW_BRANCH_EQ  = 5;
  localparam int CW_ALU_SRC    = 6;
  localparam int CW_ALU_OP     = 7;
endpackage

// File: rtl/rv_main_decoder.sv
// rv_main_decoder: combinational opcode/funct3 decode into a control word
// opcode/funct3 in; cw = control word, illegal = opcode not decodable, uses_rs2 = rs2 is read
module rv_main_decoder import rv_ctrl_pkg::*; #(
  parameter bit ENABLE_BGT = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output ctrl_word_t cw,
  output logic       illegal,
  output logic       uses_rs2
);
  always_comb begin
    cw = '0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        cw.alu_op = ALU_R;
        cw.reg_write = 1'b1;
      end
      OP_LOAD: begin
        cw.alu_op = ALU_ADD;
        cw.alu_src = 1'b1;
        cw.mem_read = 1'b1;
        cw.mem_to_reg = 1'b1;
        cw.reg_write = 1'b1;
      end
      OP_STORE: begin
        cw.alu_op = ALU_ADD;
        cw.alu_src = 1'b1;
        cw.mem_write = 1'b1;
      end
      OP_BR: begin
        if (funct3 == 3'b000) begin
          cw.alu_op = ALU_SUB;
          cw.branch_eq = 1'b1;
        end else if (ENABLE_BGT) begin
          cw.alu_op = ALU_SUB;
          cw.branch_gt = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_IALU: begin
        cw.alu_op = ALU_I;
        cw.alu_src = 1'b1;
        cw.reg_write = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end
  assign uses_rs2 = opcode inside {OP_R, OP_STORE, OP_BR};
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined main decoder with load-use stall, branch flush and perf counters
// id_* = ID instruction fields, ex_branch_taken = EX branch resolved taken;
// pc_write/ifid_write/ifid_flush steer IF; ex_*/mem_*/wb_* are the ID/EX, EX/MEM, MEM/WB controls;
// stall_cnt/flush_cnt saturate at all-ones.
module pipe_ctrl_unit import rv_ctrl_pkg::*; #(
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 16,
  parameter int ENABLE_BGT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        id_opcode,
  input  logic [2:0]        id_funct3,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_branch_eq,
  output logic              ex_branch_gt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_mem_to_reg,
  output logic              wb_reg_write,
  output logic              illegal_id,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  ctrl_word_t        id_cw, idex;
  logic [REG_AW-1:0] idex_rd;
  logic              uses_rs2, hazard, stall, bubble;
  logic              exmem_mem_to_reg, exmem_reg_write;
  rv_main_decoder #(.ENABLE_BGT(ENABLE_BGT != 0)) u_dec (
    .opcode   (id_opcode),
    .funct3   (id_funct3),
    .cw       (id_cw),
    .illegal  (illegal_id),
    .uses_rs2 (uses_rs2)
  );
  assign hazard = idex.mem_read && idex_rd != '0 &&
                  (idex_rd == id_rs1 || (uses_rs2 && idex_rd == id_rs2));
  // a taken branch squashes the ID instruction anyway, so it wins over a stall
  assign stall      = hazard && !ex_branch_taken;
  assign bubble     = hazard || ex_branch_taken;
  assign pc_write   = !stall;
  assign ifid_write = !stall;
  // gated so the IF side sees no flush while the pipeline is held in reset
  assign ifid_flush = ex_branch_taken && rst_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex             <= '0;
      idex_rd          <= '0;
      mem_read         <= 1'b0;
      mem_write        <= 1'b0;
      exmem_mem_to_reg <= 1'b0;
      exmem_reg_write  <= 1'b0;
      wb_mem_to_reg    <= 1'b0;
      wb_reg_write     <= 1'b0;
      stall_cnt        <= '0;
      flush_cnt        <= '0;
    end else begin
      idex             <= bubble ? '0 : id_cw;
      idex_rd          <= bubble ? '0 : id_rd;
      mem_read         <= idex.mem_read;
      mem_write        <= idex.mem_write;
      exmem_mem_to_reg <= idex.mem_to_reg;
      exmem_reg_write  <= idex.reg_write;
      wb_mem_to_reg    <= exmem_mem_to_reg;
      wb_reg_write     <= exmem_reg_write;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_branch_taken && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
  assign ex_alu_op    = idex.alu_op;
  assign ex_alu_src   = idex.alu_src;
  assign ex_branch_eq = idex.branch_eq;
  assign ex_branch_gt = idex.branch_gt;
  assign ex_rd        = idex_rd;
endmodule
